// File: rtl/alu_writeback_pkg.sv
// Shared register-map package: writeback record layout, architectural
// register numbers and the destination-mask helper.
package alu_writeback_pkg;

  localparam logic [3:0] REG_RAX = 4'd0;
  localparam logic [3:0] REG_RDX = 4'd2;
  localparam logic [3:0] REG_RSP = 4'd4;

  // One ALU result: up to two destinations (imul writes rdx:rax) plus retq halt.
  typedef struct packed {
    logic        dst0_en;
    logic [3:0]  dst0;
    logic [63:0] val0;
    logic        dst1_en;
    logic [3:0]  dst1;
    logic [63:0] val1;
    logic        halt;
  } wb_record_t;

  // IDLE: pending slot empty; PEND: slot holds a record that commits next edge.
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_PEND = 1'b1
  } wb_state_t;

  // One-hot bit for an enabled destination register, zero when disabled.
  function automatic logic [15:0] reg_mask(input logic en, input logic [3:0] num);
    reg_mask = en ? (16'h0001 << num) : 16'h0000;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Valid/ready result bus from the ALU into the writeback stage.
interface alu_writeback_if;

  logic        wb_valid;
  logic        wb_ready;
  logic        wb_dst0_en;
  logic [3:0]  wb_dst0;
  logic [63:0] wb_val0;
  logic        wb_dst1_en;
  logic [3:0]  wb_dst1;
  logic [63:0] wb_val1;
  logic        wb_halt;

  modport master (
    output wb_valid, wb_dst0_en, wb_dst0, wb_val0,
           wb_dst1_en, wb_dst1, wb_val1, wb_halt,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_dst0_en, wb_dst0, wb_val0,
           wb_dst1_en, wb_dst1, wb_val1, wb_halt,
    output wb_ready
  );

endinterface

// File: rtl/alu_wb_regfile.sv
// 16x64 architectural register file with two write ports and a flattened
// read-out. Port 1 has priority over port 0 on a shared address.
module alu_wb_regfile
  import alu_writeback_pkg::*;
#(
  parameter int          NREGS    = 16,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we0,
  input  logic [3:0]             waddr0,
  input  logic [63:0]            wdata0,
  input  logic                   we1,
  input  logic [3:0]             waddr1,
  input  logic [63:0]            wdata1,
  output logic [0:NREGS*64-1]    rdata_flat
);

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];

  // Next register contents: port 0 first, then port 1 so val1 wins on a clash.
  always_comb begin
    // NOTE: start from the held value so every path assigns regs_d and no latch is inferred.
    regs_d = regs_q;
    if (we0) regs_d[waddr0] = wdata0;
    if (we1) regs_d[waddr1] = wdata1;
  end

  // Register array storage; rsp comes out of reset at RSP_INIT, the rest at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is architectural state with defined reset values, so it is reset like any flop.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(REG_RSP)) ? RSP_INIT : 64'h0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flatten for the operand read: register i occupies [i*64 +: 64].
  always_comb begin
    rdata_flat = '0;
    for (int i = 0; i < NREGS; i++) begin
      rdata_flat[i*64 +: 64] = regs_q[i];
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: one-deep pending slot, busy scoreboard,
// retq halt and retired-instruction counter around the register file.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int          NREGS    = 16,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                clk,
  input  logic                reset,
  alu_writeback_if.slave      wb,
  input  logic                issue_valid,
  input  logic [15:0]         issue_mask,
  output logic [15:0]         busy,
  output logic [0:NREGS*64-1] reg_file_out,
  output logic                halted,
  output logic [31:0]         retired_count
);

  wb_state_t   state_q, state_d;
  wb_record_t  slot_q, slot_d;
  logic [15:0] busy_q, busy_d;
  logic        halted_q, halted_d;
  logic [31:0] retired_q, retired_d;

  logic        ready;
  logic        accept;
  logic        commit;
  logic [15:0] commit_mask;

  // Next-state for slot, scoreboard, halt and counter; defaults hold state.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    busy_d    = busy_q;
    halted_d  = halted_q;
    retired_d = retired_q;

    // A pending retq blocks new records so nothing slips in behind it.
    ready  = !halted_q && !(state_q == WB_PEND && slot_q.halt);
    accept = wb.wb_valid && ready;
    commit = (state_q == WB_PEND);

    commit_mask = reg_mask(commit && slot_q.dst0_en, slot_q.dst0)
                | reg_mask(commit && slot_q.dst1_en, slot_q.dst1);

    if (accept) begin
      slot_d = '{dst0_en: wb.wb_dst0_en, dst0: wb.wb_dst0, val0: wb.wb_val0,
                 dst1_en: wb.wb_dst1_en, dst1: wb.wb_dst1, val1: wb.wb_val1,
                 halt:    wb.wb_halt};
    end

    // The slot is full next cycle exactly when a record is taken this cycle.
    state_d = accept ? WB_PEND : WB_IDLE;

    // Clear committed destinations first, then OR in new issues so set wins.
    busy_d = busy_q & ~commit_mask;
    if (issue_valid && !halted_q) busy_d = busy_d | issue_mask;

    if (commit) begin
      retired_d = retired_q + 32'd1;
      if (slot_q.halt) halted_d = 1'b1;
    end
  end

  // Control and pending-slot registers; reset discards any pending record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WB_IDLE;
      slot_q    <= '0;
      busy_q    <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      slot_q    <= slot_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  alu_wb_regfile #(
    .NREGS    (NREGS),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we0        (commit && slot_q.dst0_en),
    .waddr0     (slot_q.dst0),
    .wdata0     (slot_q.val0),
    .we1        (commit && slot_q.dst1_en),
    .waddr1     (slot_q.dst1),
    .wdata1     (slot_q.val1),
    .rdata_flat (reg_file_out)
  );

  assign wb.wb_ready    = ready;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign retired_count  = retired_q;

endmodule
